// File: rtl/touch_tap_if.sv
// Touch front-end to tap-decoder bundle: raw touch samples in, clean tap events out.
// master drives the raw touch samples; slave is the decoder.
interface touch_tap_if;
    logic        touch_valid;
    logic [15:0] tp_x_coord;
    logic [15:0] tp_y_coord;
    logic        tap_valid;
    logic [19:0] hit_onehot;
    logic        start_tap;
    logic        miss_tap;
    logic [15:0] tap_x;
    logic [15:0] tap_y;
    logic        busy;

    modport master (
        output touch_valid, tp_x_coord, tp_y_coord,
        input  tap_valid, hit_onehot, start_tap, miss_tap, tap_x, tap_y, busy
    );

    modport slave (
        input  touch_valid, tp_x_coord, tp_y_coord,
        output tap_valid, hit_onehot, start_tap, miss_tap, tap_x, tap_y, busy
    );
endinterface

// File: rtl/touch_tap_decoder.sv
// Debounces raw touch points into single-cycle tap events (hole hit, start button or miss).
// Optional macro TOUCH_DRIFT_REJECT_EN: restart the press window whenever the touched class changes.
module touch_tap_decoder #(
    parameter int unsigned STABLE_CYCLES  = 500000,
    parameter int unsigned RELEASE_CYCLES = 250000,
    parameter int unsigned GRID_X0        = 80,
    parameter int unsigned GRID_Y0        = 60,
    parameter int unsigned CELL_W         = 128,
    parameter int unsigned CELL_H         = 96,
    parameter int unsigned START_X0       = 300,
    parameter int unsigned START_X1       = 500,
    parameter int unsigned START_Y0       = 420,
    parameter int unsigned START_Y1       = 470
) (
    input  logic        clk,
    input  logic        rst,
    touch_tap_if.slave  tif
);

    localparam int unsigned CNT_MAX = (STABLE_CYCLES > RELEASE_CYCLES) ? STABLE_CYCLES : RELEASE_CYCLES;
    localparam int          CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] STABLE_CNT  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] RELEASE_CNT = CNT_W'(RELEASE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {IDLE, PRESS, FIRE, HOLD, RELEASE} state_e;

    typedef struct packed {
        logic [19:0] hit;
        logic        start;
        logic        miss;
    } class_t;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             valid_q, valid_d;
    logic [15:0]      x_q, x_d, y_q, y_d;
    logic             tap_valid_q, tap_valid_d;
    logic [19:0]      hit_onehot_q, hit_onehot_d;
    logic             start_tap_q, start_tap_d;
    logic             miss_tap_q, miss_tap_d;
    logic [15:0]      tap_x_q, tap_x_d, tap_y_q, tap_y_d;

    logic [31:0] x_w, y_w;
    logic [4:0]  col_sel;
    logic [3:0]  row_sel;
    logic [19:0] grid_hit;
    logic        start_cur, present, class_changed, fire;
    class_t      cls_cur;

    assign x_w     = {16'd0, x_q};
    assign y_w     = {16'd0, y_q};
    assign present = valid_q && ((x_q != 16'd0) || (y_q != 16'd0));

    // Cell bounds are elaboration-time constants, so each cell is just two magnitude compares.
    for (genvar c = 0; c < 5; c++) begin : g_col
        localparam int unsigned LO = GRID_X0 + c * CELL_W;
        localparam int unsigned HI = LO + CELL_W;
        assign col_sel[c] = (x_w >= LO) && (x_w < HI);
    end

    for (genvar r = 0; r < 4; r++) begin : g_row
        localparam int unsigned LO = GRID_Y0 + r * CELL_H;
        localparam int unsigned HI = LO + CELL_H;
        assign row_sel[r] = (y_w >= LO) && (y_w < HI);
        for (genvar c = 0; c < 5; c++) begin : g_cell
            assign grid_hit[r*5 + c] = row_sel[r] & col_sel[c];
        end
    end

    assign start_cur     = (x_w > START_X0) && (x_w < START_X1) && (y_w > START_Y0) && (y_w < START_Y1);
    assign cls_cur.hit   = start_cur ? 20'd0 : grid_hit;
    assign cls_cur.start = start_cur;
    assign cls_cur.miss  = !start_cur && !(|grid_hit);

`ifdef TOUCH_DRIFT_REJECT_EN
    class_t cls_q, cls_d;

    // Tracking in IDLE means cls_q already holds the entry class on the first PRESS cycle.
    assign class_changed = (state_q == PRESS) && (cls_cur != cls_q);
    assign cls_d         = ((state_q == IDLE) || class_changed) ? cls_cur : cls_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cls_q <= '0;
        else     cls_q <= cls_d;
    end
`else
    assign class_changed = 1'b0;
`endif

    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_ONE;

    // State register: FSM state, counter, input stage and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            valid_q      <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            tap_valid_q  <= 1'b0;
            hit_onehot_q <= '0;
            start_tap_q  <= 1'b0;
            miss_tap_q   <= 1'b0;
            tap_x_q      <= '0;
            tap_y_q      <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values regardless of statement order.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
            x_q          <= x_d;
            y_q          <= y_d;
            tap_valid_q  <= tap_valid_d;
            hit_onehot_q <= hit_onehot_d;
            start_tap_q  <= start_tap_d;
            miss_tap_q   <= miss_tap_d;
            tap_x_q      <= tap_x_d;
            tap_y_q      <= tap_y_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a signal unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = tif.touch_valid;
        x_d     = tif.tp_x_coord;
        y_d     = tif.tp_y_coord;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (present) begin
                    state_d = PRESS;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS: begin
                if (!present) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (class_changed) begin
                    cnt_d = CNT_ONE;
                end else if (cnt_q == STABLE_CNT) begin
                    state_d = FIRE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            FIRE: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
            HOLD: begin
                if (!present) begin
                    state_d = RELEASE;
                    cnt_d   = CNT_ONE;
                end
            end
            RELEASE: begin
                if (present) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == RELEASE_CNT) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are loaded on the edge that enters FIRE, so the pulse coincides with the FIRE state.
    always_comb begin
        fire         = (state_d == FIRE);
        tap_valid_d  = fire;
        hit_onehot_d = fire ? cls_cur.hit : 20'd0;
        start_tap_d  = fire && cls_cur.start;
        miss_tap_d   = fire && cls_cur.miss;
        tap_x_d      = fire ? x_q : tap_x_q;
        tap_y_d      = fire ? y_q : tap_y_q;
    end

    assign tif.tap_valid  = tap_valid_q;
    assign tif.hit_onehot = hit_onehot_q;
    assign tif.start_tap  = start_tap_q;
    assign tif.miss_tap   = miss_tap_q;
    assign tif.tap_x      = tap_x_q;
    assign tif.tap_y      = tap_y_q;
    assign tif.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_touch_tap_decoder.sv
// Directed bench for touch_tap_decoder with short debounce windows (STABLE=4, RELEASE=3).
// Expected tap cycles are relative to the cycle the touch is first driven.
module tb_touch_tap_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    touch_tap_if tif();

    touch_tap_decoder #(
        .STABLE_CYCLES  (4),
        .RELEASE_CYCLES (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .tif (tif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        int          hold;
        int          exp_taps;
        logic [19:0] exp_hit;
        logic        exp_start;
        logic        exp_miss;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int t0     = 0;
    int tap_cnt;
    int first_cyc;
    int viol;
    logic [19:0] f_hit;
    logic        f_start, f_miss;
    int exp_drift_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, sample outputs on the falling edge, advance past the rising edge.
    task automatic step(input logic v, input logic [15:0] x, input logic [15:0] y);
        int nq;
        tif.touch_valid = v;
        tif.tp_x_coord  = x;
        tif.tp_y_coord  = y;
        @(negedge clk);
        nq = int'(tif.hit_onehot != 20'd0) + int'(tif.start_tap) + int'(tif.miss_tap);
        if (tif.tap_valid === 1'b1) begin
            tap_cnt++;
            if (tap_cnt == 1) begin
                first_cyc = cyc - t0;
                f_hit     = tif.hit_onehot;
                f_start   = tif.start_tap;
                f_miss    = tif.miss_tap;
            end
            if (nq != 1 || (tif.hit_onehot != 20'd0 && !$onehot(tif.hit_onehot))) viol++;
        end else if (nq != 0 || tif.tap_valid !== 1'b0) begin
            viol++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic begin_window();
        tap_cnt   = 0;
        first_cyc = -1;
        viol      = 0;
        t0        = cyc;
    endtask

    task automatic run_vec(input int i);
        repeat (8) step(1'b0, 16'd0, 16'd0);
        begin_window();
        repeat (vecs[i].hold) step(1'b1, vecs[i].x, vecs[i].y);
        repeat (8) step(1'b0, 16'd0, 16'd0);
        check($sformatf("v%0d tap_count", i), 32'(tap_cnt), 32'(vecs[i].exp_taps));
        check($sformatf("v%0d qualifiers", i), 32'(viol), 32'd0);
        check($sformatf("v%0d busy_after", i), 32'(tif.busy), 32'd0);
        if (vecs[i].exp_taps > 0) begin
            check($sformatf("v%0d tap_cycle", i), 32'(first_cyc), 32'd6);
            check($sformatf("v%0d hit_onehot", i), 32'(f_hit), 32'(vecs[i].exp_hit));
            check($sformatf("v%0d start_tap", i), 32'(f_start), 32'(vecs[i].exp_start));
            check($sformatf("v%0d miss_tap", i), 32'(f_miss), 32'(vecs[i].exp_miss));
            check($sformatf("v%0d tap_x", i), 32'(tif.tap_x), 32'(vecs[i].x));
            check($sformatf("v%0d tap_y", i), 32'(tif.tap_y), 32'(vecs[i].y));
        end
    endtask

    initial begin
        //            x        y      hold taps hit          start miss
        vecs[0]  = '{16'd100, 16'd70,  20, 1, 20'h00001, 1'b0, 1'b0};
        vecs[1]  = '{16'd400, 16'd450, 10, 1, 20'h00000, 1'b1, 1'b0};
        vecs[2]  = '{16'd10,  16'd10,  10, 1, 20'h00000, 1'b0, 1'b1};
        vecs[3]  = '{16'd600, 16'd380,  3, 0, 20'h00000, 1'b0, 1'b0};
        vecs[4]  = '{16'd600, 16'd380, 10, 1, 20'h80000, 1'b0, 1'b0};
        vecs[5]  = '{16'd207, 16'd155, 10, 1, 20'h00001, 1'b0, 1'b0};
        vecs[6]  = '{16'd208, 16'd156, 10, 1, 20'h00040, 1'b0, 1'b0};
        vecs[7]  = '{16'd719, 16'd443, 10, 1, 20'h80000, 1'b0, 1'b0};
        vecs[8]  = '{16'd720, 16'd100, 10, 1, 20'h00000, 1'b0, 1'b1};
        vecs[9]  = '{16'd300, 16'd450, 10, 1, 20'h00000, 1'b0, 1'b1};
        vecs[10] = '{16'd301, 16'd421, 10, 1, 20'h00000, 1'b1, 1'b0};
        vecs[11] = '{16'd499, 16'd469, 10, 1, 20'h00000, 1'b1, 1'b0};
        vecs[12] = '{16'd79,  16'd60,  10, 1, 20'h00000, 1'b0, 1'b1};
        vecs[13] = '{16'd0,   16'd0,   10, 0, 20'h00000, 1'b0, 1'b0};
        vecs[14] = '{16'd0,   16'd5,   10, 1, 20'h00000, 1'b0, 1'b1};
        vecs[15] = '{16'd336, 16'd252, 10, 1, 20'h01000, 1'b0, 1'b0};

        tif.touch_valid = 1'b0;
        tif.tp_x_coord  = 16'd0;
        tif.tp_y_coord  = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset tap_valid", 32'(tif.tap_valid), 32'd0);
        check("reset hit_onehot", 32'(tif.hit_onehot), 32'd0);
        check("reset busy", 32'(tif.busy), 32'd0);
        check("reset tap_x", 32'(tif.tap_x), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) run_vec(i);

        // Short lift then re-touch must not re-arm; a long lift must.
        repeat (8) step(1'b0, 16'd0, 16'd0);
        begin_window();
        repeat (10) step(1'b1, 16'd100, 16'd70);
        repeat (2)  step(1'b0, 16'd0, 16'd0);
        repeat (10) step(1'b1, 16'd100, 16'd70);
        repeat (8)  step(1'b0, 16'd0, 16'd0);
        check("short_lift tap_count", 32'(tap_cnt), 32'd1);
        begin_window();
        repeat (10) step(1'b1, 16'd100, 16'd70);
        repeat (5)  step(1'b0, 16'd0, 16'd0);
        repeat (10) step(1'b1, 16'd208, 16'd70);
        repeat (8)  step(1'b0, 16'd0, 16'd0);
        check("long_lift tap_count", 32'(tap_cnt), 32'd2);
        check("long_lift tap_x", 32'(tif.tap_x), 32'd208);
        check("long_lift qualifiers", 32'(viol), 32'd0);

        // Coordinate drift during the press window.
`ifdef TOUCH_DRIFT_REJECT_EN
        exp_drift_cyc = 8;
`else
        exp_drift_cyc = 6;
`endif
        begin_window();
        repeat (2)  step(1'b1, 16'd100, 16'd70);
        repeat (12) step(1'b1, 16'd240, 16'd70);
        repeat (8)  step(1'b0, 16'd0, 16'd0);
        check("drift tap_count", 32'(tap_cnt), 32'd1);
        check("drift tap_cycle", 32'(first_cyc), 32'(exp_drift_cyc));
        check("drift hit_onehot", 32'(f_hit), 32'h00002);
        check("drift tap_x", 32'(tif.tap_x), 32'd240);

        // Asynchronous reset in PRESS with counter = 3 (cycle 4 of the touch).
        begin_window();
        repeat (4) step(1'b1, 16'd600, 16'd380);
        @(negedge clk);
        check("pre_reset busy", 32'(tif.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst tap_valid", 32'(tif.tap_valid), 32'd0);
        check("async_rst hit_onehot", 32'(tif.hit_onehot), 32'd0);
        check("async_rst start_miss", {30'd0, tif.start_tap, tif.miss_tap}, 32'd0);
        check("async_rst tap_x", 32'(tif.tap_x), 32'd0);
        check("async_rst tap_y", 32'(tif.tap_y), 32'd0);
        check("async_rst busy", 32'(tif.busy), 32'd0);
        @(posedge clk);
        #1;
        cyc++;
        repeat (3) step(1'b1, 16'd600, 16'd380);
        check("in_reset tap_count", 32'(tap_cnt), 32'd0);
        rst = 1'b0;
        begin_window();
        repeat (10) step(1'b1, 16'd600, 16'd380);
        repeat (8)  step(1'b0, 16'd0, 16'd0);
        check("post_rst tap_count", 32'(tap_cnt), 32'd1);
        check("post_rst tap_cycle", 32'(first_cyc), 32'd6);
        check("post_rst hit_onehot", 32'(f_hit), 32'h80000);
        check("post_rst busy", 32'(tif.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
